// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and FSM state encodings for mem_arbiter
package mem_arbiter_pkg;

    localparam int ARB_RW  = 16;
    localparam int ARB_ISZ = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_F = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and memory bus signals of mem_arbiter
interface mem_arbiter_if #(
    parameter int RW  = 16,
    parameter int ISZ = 32
);
    logic [RW-1:0]  f_addr;
    logic           f_submit;
    logic [ISZ-1:0] f_data;
    logic           f_ack;

    logic [RW-1:0]  d_addr;
    logic [RW-1:0]  d_wdata;
    logic           d_we;
    logic           d_submit;
    logic [RW-1:0]  d_data;
    logic           d_ack;

    logic           bus_req;
    logic [RW-1:0]  bus_addr;
    logic           bus_we;
    logic [RW-1:0]  bus_wdata;
    logic           bus_instr;
    logic           bus_ack;
    logic [ISZ-1:0] bus_rdata;

    // Arbiter side
    modport slave (
        input  f_addr, f_submit, d_addr, d_wdata, d_we, d_submit, bus_ack, bus_rdata,
        output f_data, f_ack, d_data, d_ack, bus_req, bus_addr, bus_we, bus_wdata, bus_instr
    );

    // Core / memory side
    modport master (
        output f_addr, f_submit, d_addr, d_wdata, d_we, d_submit, bus_ack, bus_rdata,
        input  f_data, f_ack, d_data, d_ack, bus_req, bus_addr, bus_we, bus_wdata, bus_instr
    );
endinterface

// File: rtl/mem_arbiter_slot.sv
// rtl/mem_arbiter_slot.sv - one pending-request register; clear beats load so a granted submit is consumed
module arb_req_slot #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         pend_o,
    output logic [W-1:0] data_o
);
    logic         pend_q, pend_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q;
        data_d = data_q;
        if (clear_i) begin
            pend_d = 1'b0;
        end else if (load_i) begin
            pend_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign pend_o = pend_q;
    assign data_o = data_q;
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between fetch and data ports, data first with fetch starvation guard
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RW         = ARB_RW,
    parameter int ISZ        = ARB_ISZ,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bif
);
    localparam int          DW         = 2 * RW + 1;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e     state_q;
    logic [3:0]     starve_q;
    logic           bus_req_q;
    logic [RW-1:0]  bus_addr_q;
    logic           bus_we_q;
    logic [RW-1:0]  bus_wdata_q;
    logic           bus_instr_q;

    logic           f_pend, d_pend;
    logic [RW-1:0]  f_slot;
    logic [DW-1:0]  d_slot;
    logic [DW-1:0]  d_word;
    logic           f_avail, d_avail;
    logic [RW-1:0]  f_eff;
    logic [DW-1:0]  d_eff;
    logic           can_grant, gnt_f, gnt_d;
    logic [ISZ-1:0] rdata_w;

    assign d_word = {bif.d_we, bif.d_wdata, bif.d_addr};

    arb_req_slot #(.W(RW)) u_f_slot (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (bif.f_submit),
        .clear_i (gnt_f),
        .data_i  (bif.f_addr),
        .pend_o  (f_pend),
        .data_o  (f_slot)
    );

    arb_req_slot #(.W(DW)) u_d_slot (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (bif.d_submit),
        .clear_i (gnt_d),
        .data_i  (d_word),
        .pend_o  (d_pend),
        .data_o  (d_slot)
    );

    // Same-cycle submits take part in arbitration and override a stale slot value
    assign f_avail   = f_pend | bif.f_submit;
    assign d_avail   = d_pend | bif.d_submit;
    assign f_eff     = bif.f_submit ? bif.f_addr : f_slot;
    assign d_eff     = bif.d_submit ? d_word : d_slot;
    assign can_grant = (state_q == ARB_IDLE) | bif.bus_ack;
    assign gnt_f     = can_grant & f_avail & (~d_avail | (starve_q == STARVE_LIM));
    assign gnt_d     = can_grant & d_avail & ~gnt_f;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            starve_q    <= 4'd0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            bus_instr_q <= 1'b0;
        end else begin
            if (gnt_f) begin
                state_q     <= ARB_BUSY_F;
                bus_req_q   <= 1'b1;
                bus_addr_q  <= f_eff;
                bus_we_q    <= 1'b0;
                bus_wdata_q <= '0;
                bus_instr_q <= 1'b1;
            end else if (gnt_d) begin
                state_q     <= ARB_BUSY_D;
                bus_req_q   <= 1'b1;
                bus_addr_q  <= d_eff[RW-1:0];
                bus_wdata_q <= d_eff[2*RW-1:RW];
                bus_we_q    <= d_eff[2*RW];
                bus_instr_q <= 1'b0;
            end else if (state_q != ARB_IDLE && bif.bus_ack) begin
                state_q   <= ARB_IDLE;
                bus_req_q <= 1'b0;
            end

            if (gnt_f || !f_avail) begin
                starve_q <= 4'd0;
            end else if (gnt_d && starve_q != STARVE_LIM) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

    assign rdata_w       = bif.bus_rdata;
    assign bif.f_ack     = (state_q == ARB_BUSY_F) & bif.bus_ack;
    assign bif.d_ack     = (state_q == ARB_BUSY_D) & bif.bus_ack;
    assign bif.f_data    = bif.f_ack ? rdata_w : '0;
    assign bif.d_data    = bif.d_ack ? rdata_w[RW-1:0] : '0;
    assign bif.bus_req   = bus_req_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_we    = bus_we_q;
    assign bif.bus_wdata = bus_wdata_q;
    assign bif.bus_instr = bus_instr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   fack_cnt;

    mem_arbiter_if #(.RW(16), .ISZ(32)) bif ();

    mem_arbiter #(.RW(16), .ISZ(32), .STARVE_MAX(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bif.f_ack === 1'b1) fack_cnt <= fack_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.f_submit  = 1'b0;
        bif.d_submit  = 1'b0;
        bif.bus_ack   = 1'b0;
        bif.f_addr    = '0;
        bif.d_addr    = '0;
        bif.d_wdata   = '0;
        bif.d_we      = 1'b0;
        bif.bus_rdata = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic [15:0] addr,
                           input logic we, input logic [15:0] wdata, input logic instr);
        chk({tag, "_req"},   32'(bif.bus_req),   32'(req));
        chk({tag, "_addr"},  32'(bif.bus_addr),  32'(addr));
        chk({tag, "_we"},    32'(bif.bus_we),    32'(we));
        chk({tag, "_wdata"}, 32'(bif.bus_wdata), 32'(wdata));
        chk({tag, "_instr"}, 32'(bif.bus_instr), 32'(instr));
    endtask

    int fack_base;

    initial begin
        checks   = 0;
        failures = 0;
        fack_cnt = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_bus("reset", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("reset_fack",  32'(bif.f_ack),  32'h0);
        chk("reset_dack",  32'(bif.d_ack),  32'h0);
        chk("reset_fdata", bif.f_data,      32'h0);
        chk("reset_ddata", 32'(bif.d_data), 32'h0);

        // Single fetch
        bif.f_submit = 1'b1; bif.f_addr = 16'h0010;
        tick();
        idle_inputs();
        chk_bus("f1_issue", 1'b1, 16'h0010, 1'b0, 16'h0, 1'b1);
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEADBEEF;
        #1;
        chk("f1_fack",  32'(bif.f_ack), 32'h1);
        chk("f1_fdata", bif.f_data,     32'hDEADBEEF);
        chk("f1_dack",  32'(bif.d_ack), 32'h0);
        tick();
        idle_inputs();
        chk("f1_done_req", 32'(bif.bus_req), 32'h0);

        // Simultaneous fetch and data write: data first
        bif.f_submit = 1'b1; bif.f_addr = 16'h0020;
        bif.d_submit = 1'b1; bif.d_addr = 16'h8000; bif.d_wdata = 16'h1234; bif.d_we = 1'b1;
        tick();
        idle_inputs();
        chk_bus("sim_d", 1'b1, 16'h8000, 1'b1, 16'h1234, 1'b0);
        tick();
        chk_bus("sim_d_hold", 1'b1, 16'h8000, 1'b1, 16'h1234, 1'b0);
        bif.bus_ack = 1'b1;
        #1;
        chk("sim_dack", 32'(bif.d_ack), 32'h1);
        chk("sim_fack", 32'(bif.f_ack), 32'h0);
        tick();
        idle_inputs();
        chk_bus("sim_f", 1'b1, 16'h0020, 1'b0, 16'h0, 1'b1);
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h11112222;
        #1;
        chk("sim_f_fack",  32'(bif.f_ack), 32'h1);
        chk("sim_f_fdata", bif.f_data,     32'h11112222);
        tick();
        idle_inputs();
        chk("sim_done_req", 32'(bif.bus_req), 32'h0);

        // Starvation: data submits every grant while fetch 0x0040 waits
        bif.f_submit = 1'b1; bif.f_addr = 16'h0040;
        bif.d_submit = 1'b1; bif.d_addr = 16'h0200;
        tick();
        idle_inputs();
        chk_bus("stv_d0", 1'b1, 16'h0200, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            bif.d_submit = 1'b1; bif.d_addr = 16'h0200 + 16'(i);
            bif.bus_ack = 1'b1;
            #1;
            chk("stv_dack", 32'(bif.d_ack), 32'h1);
            tick();
            idle_inputs();
            chk_bus("stv_dn", 1'b1, 16'h0200 + 16'(i), 1'b0, 16'h0, 1'b0);
        end
        chk("stv_cnt_max", 32'(dut.starve_q), 32'h4);
        bif.d_submit = 1'b1; bif.d_addr = 16'h0204;
        bif.bus_ack = 1'b1;
        tick();
        idle_inputs();
        chk_bus("stv_forced_f", 1'b1, 16'h0040, 1'b0, 16'h0, 1'b1);
        chk("stv_cnt_clr", 32'(dut.starve_q), 32'h0);
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h00400040;
        #1;
        chk("stv_fack", 32'(bif.f_ack), 32'h1);
        tick();
        idle_inputs();
        chk_bus("stv_d_after", 1'b1, 16'h0204, 1'b0, 16'h0, 1'b0);
        bif.bus_ack = 1'b1;
        tick();
        idle_inputs();
        chk("stv_done_req", 32'(bif.bus_req), 32'h0);

        // Fetch overwrite while data access is busy
        fack_base = fack_cnt;
        bif.d_submit = 1'b1; bif.d_addr = 16'h0300;
        tick();
        idle_inputs();
        bif.f_submit = 1'b1; bif.f_addr = 16'h0030;
        tick();
        bif.f_addr = 16'h0031;
        tick();
        idle_inputs();
        bif.bus_ack = 1'b1;
        #1;
        chk("ow_dack", 32'(bif.d_ack), 32'h1);
        tick();
        idle_inputs();
        chk_bus("ow_f", 1'b1, 16'h0031, 1'b0, 16'h0, 1'b1);
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCAFE0031;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("ow_req_idle", 32'(bif.bus_req), 32'h0);
        chk("ow_fack_total", 32'(fack_cnt - fack_base), 32'h1);

        // Reset mid-transaction with fetch pending
        bif.f_submit = 1'b1; bif.f_addr = 16'h0050;
        bif.d_submit = 1'b1; bif.d_addr = 16'h0400; bif.d_wdata = 16'hBEEF; bif.d_we = 1'b1;
        tick();
        idle_inputs();
        chk("rst_busy_d", 32'(dut.state_q), 32'(ARB_BUSY_D));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_req",   32'(bif.bus_req), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h55555555;
        #1;
        chk("rst_stray_fack", 32'(bif.f_ack), 32'h0);
        chk("rst_stray_dack", 32'(bif.d_ack), 32'h0);
        tick();
        idle_inputs();
        chk("rst_no_regrant", 32'(bif.bus_req), 32'h0);

        // Data submit in the ack cycle of a prior data read
        bif.d_submit = 1'b1; bif.d_addr = 16'h0500;
        tick();
        idle_inputs();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1234ABCD;
        bif.d_submit = 1'b1; bif.d_addr = 16'h0100;
        #1;
        chk("b2b_dack",  32'(bif.d_ack),  32'h1);
        chk("b2b_ddata", 32'(bif.d_data), 32'h0000ABCD);
        tick();
        idle_inputs();
        chk_bus("b2b_next", 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
        bif.bus_ack = 1'b1;
        tick();
        idle_inputs();
        chk("b2b_done_req", 32'(bif.bus_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
